viterbi_acs4: RTL and testbench

Add-compare-select stage of the rate-1/2, constraint-length-3 (generators 7/5 octal) Viterbi decoder. It sits directly downstream of branch metric computation and consumes the four 2-bit Hamming branch metrics for each received symbol pair. It maintains the four registered path metrics, renormalises them every step, and emits one survivor decision bit per state to the traceback stage.

---
 rtl/viterbi_acs4.sv | 155 +++++++++++++++
 tb/tb_viterbi_acs4.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_acs4.sv
// Add-compare-select stage for the rate-1/2, K=3 (7/5 octal) Viterbi decoder.
// Keeps four renormalised path metrics and emits one survivor decision per state.
module viterbi_acs4 #(
    parameter int PM_W    = 8,
    parameter int INIT_PM = 2 ** (PM_W - 2)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic [1:0]      bm00,
    input  logic [1:0]      bm01,
    input  logic [1:0]      bm10,
    input  logic [1:0]      bm11,
    output logic            out_valid,
    output logic [3:0]      dec,
    output logic [1:0]      best_state,
    output logic [PM_W-1:0] pm0,
    output logic [PM_W-1:0] pm1,
    output logic [PM_W-1:0] pm2,
    output logic [PM_W-1:0] pm3,
    output logic [15:0]     sym_cnt
);

    typedef logic [PM_W-1:0] pm_t;
    typedef logic [PM_W:0]   sum_t;

    localparam pm_t INIT_V = pm_t'(INIT_PM);

    pm_t         pm_r [4];
    logic [3:0]  dec_r;
    logic [1:0]  best_r;
    logic        valid_r;
    logic [15:0] cnt_r;

    pm_t         old_s [4];
    sum_t        cand_a_s [4];
    sum_t        cand_b_s [4];
    sum_t        sel_s [4];
    sum_t        min_s;
    logic        lt_s;
    pm_t         norm_s [4];
    logic [3:0]  dec_s;
    logic [1:0]  best_s;
    logic [15:0] cnt_nxt_s;

    // Frame-start metric for a given state: state 0 is the known encoder start.
    function automatic pm_t init_metric(input int idx);
        if (idx == 0) begin
            return {PM_W{1'b0}};
        end else begin
            return INIT_V;
        end
    endfunction

    // Old metrics: a start pulse substitutes the initial values in the same cycle.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            if (start) begin
                old_s[n] = init_metric(n);
            end else begin
                old_s[n] = pm_r[n];
            end
        end
    end

    // Candidate sums, one bit wider than the metrics so nothing wraps before selection.
    always_comb begin
        cand_a_s[0] = sum_t'(old_s[0]) + sum_t'(bm00);
        cand_b_s[0] = sum_t'(old_s[1]) + sum_t'(bm11);
        cand_a_s[1] = sum_t'(old_s[2]) + sum_t'(bm10);
        cand_b_s[1] = sum_t'(old_s[3]) + sum_t'(bm01);
        cand_a_s[2] = sum_t'(old_s[0]) + sum_t'(bm11);
        cand_b_s[2] = sum_t'(old_s[1]) + sum_t'(bm00);
        cand_a_s[3] = sum_t'(old_s[2]) + sum_t'(bm01);
        cand_b_s[3] = sum_t'(old_s[3]) + sum_t'(bm10);
    end

    // Compare-select, minimum search and renormalisation; ties favour the LSB-0 predecessor.
    always_comb begin
        dec_s  = 4'b0000;
        min_s  = {(PM_W + 1){1'b0}};
        best_s = 2'd0;
        lt_s   = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (cand_b_s[n] < cand_a_s[n]) begin
                sel_s[n] = cand_b_s[n];
                dec_s[n] = 1'b1;
            end else begin
                sel_s[n] = cand_a_s[n];
                dec_s[n] = 1'b0;
            end
        end
        min_s = sel_s[0];
        for (int n = 1; n < 4; n++) begin
            lt_s   = (sel_s[n] < min_s);
            best_s = lt_s ? 2'(n) : best_s;
            min_s  = lt_s ? sel_s[n] : min_s;
        end
        for (int n = 0; n < 4; n++) begin
            norm_s[n] = pm_t'(sel_s[n] - min_s);
        end
    end

    // Symbol counter: restarts on start, saturates at all-ones.
    always_comb begin
        if (start) begin
            cnt_nxt_s = in_valid ? 16'd1 : 16'd0;
        end else if (in_valid && (cnt_r != 16'hFFFF)) begin
            cnt_nxt_s = cnt_r + 16'd1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < 4; n++) begin
                pm_r[n] <= init_metric(n);
            end
            dec_r   <= 4'b0000;
            best_r  <= 2'd0;
            valid_r <= 1'b0;
            cnt_r   <= 16'd0;
        end else begin
            valid_r <= in_valid;
            cnt_r   <= cnt_nxt_s;
            if (in_valid) begin
                for (int n = 0; n < 4; n++) begin
                    pm_r[n] <= norm_s[n];
                end
                dec_r  <= dec_s;
                best_r <= best_s;
            end else if (start) begin
                for (int n = 0; n < 4; n++) begin
                    pm_r[n] <= old_s[n];
                end
            end else begin
                dec_r  <= dec_r;
                best_r <= best_r;
            end
        end
    end

    assign out_valid  = valid_r;
    assign dec        = dec_r;
    assign best_state = best_r;
    assign pm0        = pm_r[0];
    assign pm1        = pm_r[1];
    assign pm2        = pm_r[2];
    assign pm3        = pm_r[3];
    assign sym_cnt    = cnt_r;

endmodule

// File: tb/tb_viterbi_acs4.sv
// Directed bench for viterbi_acs4: hand-computed vectors plus a trellis-walking model
// built from the encoder equations.
module tb_viterbi_acs4;

    localparam int PM_W    = 8;
    localparam int INIT_PM = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            in_valid;
    logic [1:0]      bm00, bm01, bm10, bm11;
    logic            out_valid;
    logic [3:0]      dec;
    logic [1:0]      best_state;
    logic [PM_W-1:0] pm0, pm1, pm2, pm3;
    logic [15:0]     sym_cnt;

    int total = 0;
    int bad   = 0;

    int         m_pm [4];
    logic [3:0] m_dec;
    int         m_best;
    int         m_cnt;
    logic       m_valid;

    viterbi_acs4 #(.PM_W(PM_W), .INIT_PM(INIT_PM)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .bm00(bm00), .bm01(bm01), .bm10(bm10), .bm11(bm11),
        .out_valid(out_valid), .dec(dec), .best_state(best_state),
        .pm0(pm0), .pm1(pm1), .pm2(pm2), .pm3(pm3), .sym_cnt(sym_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int hd(input logic [1:0] a, input logic [1:0] b);
        return int'(a[1] ^ b[1]) + int'(a[0] ^ b[0]);
    endfunction

    function automatic logic [1:0] code_sym(input int p, input int u);
        logic s1, s0, ub;
        s1 = p[1];
        s0 = p[0];
        ub = u[0];
        return {ub ^ s1 ^ s0, ub ^ s0};
    endfunction

    function automatic int pm_of(input int idx);
        case (idx)
            0:       return int'(pm0);
            1:       return int'(pm1);
            2:       return int'(pm2);
            default: return int'(pm3);
        endcase
    endfunction

    task automatic model_reset();
        m_pm    = '{0, INIT_PM, INIT_PM, INIT_PM};
        m_dec   = 4'b0000;
        m_best  = 0;
        m_cnt   = 0;
        m_valid = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic v, input logic [1:0] rx);
        int old [4];
        int sel [4];
        int a, b, mn, u, p0;
        if (s) old = '{0, INIT_PM, INIT_PM, INIT_PM};
        else   old = m_pm;
        m_valid = v;
        if (v) begin
            for (int ns = 0; ns < 4; ns++) begin
                u  = ns / 2;
                p0 = (ns % 2) * 2;
                a  = old[p0]     + hd(rx, code_sym(p0, u));
                b  = old[p0 + 1] + hd(rx, code_sym(p0 + 1, u));
                m_dec[ns] = (b < a);
                sel[ns]   = (b < a) ? b : a;
            end
            mn = sel[0];
            m_best = 0;
            for (int ns = 1; ns < 4; ns++) begin
                if (sel[ns] < mn) begin
                    mn = sel[ns];
                    m_best = ns;
                end
            end
            for (int ns = 0; ns < 4; ns++) m_pm[ns] = (sel[ns] - mn) % 256;
            m_cnt = s ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : m_cnt);
        end else if (s) begin
            m_pm  = old;
            m_cnt = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".out_valid"}, out_valid, m_valid);
        check({tag, ".pm0"}, pm0, m_pm[0]);
        check({tag, ".pm1"}, pm1, m_pm[1]);
        check({tag, ".pm2"}, pm2, m_pm[2]);
        check({tag, ".pm3"}, pm3, m_pm[3]);
        check({tag, ".dec"}, dec, m_dec);
        check({tag, ".best"}, best_state, m_best);
        check({tag, ".sym_cnt"}, sym_cnt, m_cnt);
    endtask

    task automatic drive(input string tag, input logic s, input logic v, input logic [1:0] rx);
        @(negedge clk);
        start    = s;
        in_valid = v;
        bm00     = 2'(hd(rx, 2'b00));
        bm01     = 2'(hd(rx, 2'b01));
        bm10     = 2'(hd(rx, 2'b10));
        bm11     = 2'(hd(rx, 2'b11));
        @(posedge clk);
        #1;
        model_step(s, v, rx);
        compare_all(tag);
    endtask

    // Reset asserted between edges; outputs must already be at reset values before the next edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    logic [1:0] rx_ok  [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    int         st_ok  [6] = '{2, 1, 2, 3, 1, 0};
    logic [1:0] rx_err [8] = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
    int         st_err [8] = '{2, 1, 2, 3, 1, 0, 0, 0};

    initial begin
        int pulses;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        bm00 = 2'd0; bm01 = 2'd0; bm10 = 2'd0; bm11 = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Single rx=00 symbol from reset
        drive("first", 1'b0, 1'b1, 2'b00);
        check("first.pm0", pm0, 0);
        check("first.pm1", pm1, 65);
        check("first.pm2", pm2, 2);
        check("first.pm3", pm3, 65);
        check("first.dec", dec, 4'b0000);
        check("tie.dec1", dec[1], 1'b0);
        check("first.best", best_state, 0);
        check("first.cnt", sym_cnt, 1);

        // Error-free encoding of 1,0,1,1,0,0
        async_reset("rst1");
        for (int i = 0; i < 6; i++) begin
            drive("clean", 1'b0, 1'b1, rx_ok[i]);
            check("clean.true_pm", pm_of(st_ok[i]), 0);
            check("clean.best", best_state, st_ok[i]);
        end
        check("clean.cnt", sym_cnt, 6);

        // Same stream with one flipped bit plus two flush zeros, framed by start
        for (int i = 0; i < 8; i++) begin
            drive("err", (i == 0), 1'b1, rx_err[i]);
            if (i == 0) check("err.start_cnt", sym_cnt, 1);
            if (i >= 2) begin
                for (int k = 0; k < 4; k++) check("err.bound", (pm_of(k) <= 4), 1'b1);
            end
        end
        check("err.final_pm0", pm0, 0);
        check("err.final_best", best_state, st_err[7]);
        check("err.cnt", sym_cnt, 8);

        // Valid symbols separated by three idle cycles
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            drive("gap.v", 1'b0, 1'b1, rx_ok[i]);
            if (out_valid) pulses++;
            for (int j = 0; j < 3; j++) begin
                drive("gap.idle", 1'b0, 1'b0, 2'b11);
                if (out_valid) pulses++;
            end
        end
        check("gap.pulses", pulses, 3);
        check("gap.cnt", sym_cnt, 11);

        // Start alone: initialise only, dec/best hold
        drive("start_only", 1'b1, 1'b0, 2'b00);
        check("start_only.pm1", pm1, 64);
        check("start_only.cnt", sym_cnt, 0);
        drive("mid", 1'b0, 1'b1, 2'b01);
        drive("mid", 1'b0, 1'b1, 2'b10);

        // Start with a valid rx=11 symbol mid-frame
        drive("start_v", 1'b1, 1'b1, 2'b11);
        check("start_v.pm0", pm0, 2);
        check("start_v.pm1", pm1, 65);
        check("start_v.pm2", pm2, 0);
        check("start_v.pm3", pm3, 65);
        check("start_v.best", best_state, 2);
        check("start_v.cnt", sym_cnt, 1);

        // Asynchronous reset mid-stream, then a fresh frame
        drive("pre_rst", 1'b0, 1'b1, 2'b01);
        async_reset("rst2");
        drive("fresh", 1'b0, 1'b1, 2'b00);
        check("fresh.pm1", pm1, 65);
        check("fresh.pm2", pm2, 2);
        check("fresh.cnt", sym_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
